sm4_axis_pack32to128: RTL and testbench
=======================================

# sm4_axis_pack32to128

Upstream width converter and block former for the SM4 AXI-Stream engine. Accepts a 32-bit AXI-Stream payload, packs four consecutive words into one 128-bit SM4 block in big-endian order, and pads the final partial block on `tlast`. Presents a registered 128-bit AXI-Stream master that connects directly to the engine's 128-bit slave port. Honours downstream backpressure through `tready`.

## Interface
Parameters:
- `PAD_MODE`, default 0: 0 = zero-fill partial final block; 1 = word-granular ISO/IEC 7816-4 padding (first pad word 32'h8000_0000, rest zero; a full final block gets one extra pad block).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  32  payload word.
- `s_axis_tvalid`  in  1  word valid.
- `s_axis_tlast`  in  1  last word of message.
- `s_axis_tready`  out  1  word accepted when high with `s_axis_tvalid`.
- `m_axis_tdata`  out  128  packed block; first word of the block in [127:96].
- `m_axis_tvalid`  out  1  block valid.
- `m_axis_tlast`  out  1  last block of message.
- `m_axis_tnwords`  out  3  payload words in block, 0..4 (0 only for the PAD_MODE=1 extra block).
- `m_axis_tready`  in  1  downstream accepts block.

## Operation
- Accumulator: three 32-bit word registers plus 2-bit index `idx` (0..3).
- Accepted beat with `idx`<3 and `tlast`=0: store word at slot `idx`, `idx`+1.
- Completing beat (`idx`==3, or `tlast`=1): load output register with stored words, current word, then padding; `idx`<=0.
- Padding, `PAD_MODE`=0: remaining slots zero; `tnwords`=`idx`+1; `tlast` as received.
- Padding, `PAD_MODE`=1, partial block: first free slot 32'h8000_0000, rest zero; `tlast`=1.
- Padding, `PAD_MODE`=1, full block (`idx`==3 with `tlast`): emit the block with `tlast`=0, `tnwords`=4, then enter PAD. In PAD, emit 128'h8000_0000_0000...0 with `tnwords`=0 and `tlast`=1, then return to ACC.
- FSM states:
  - ACC: normal packing.
  - PAD: waiting to load the extra pad block. Entered only as above; left when the output register is free or draining.
- `s_axis_tready` = `reset_n` & (state==ACC) & (!`m_axis_tvalid` | `m_axis_tready`). This is a combinational path from `m_axis_tready`, and it is applied to every beat, including non-completing beats.
- Output register: on load, `m_axis_tvalid`<=1. It holds all payload stable until `m_axis_tready`. On a handshake with no new load, `m_axis_tvalid`<=0.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `m_axis_tnwords`=0, `idx`=0, state=ACC. `s_axis_tready`=0 while `reset_n` is low.
- Latency: block is valid on the cycle after its completing beat is accepted.
- Throughput: one 32-bit word per cycle sustained with `m_axis_tready` held high, giving one block every 4 cycles.
- Simultaneous output handshake and new completing beat: the new block replaces the old one with `m_axis_tvalid` remaining 1, so there is no bubble.
- PAD entry: the next cycle loads the pad block if the output register drains that cycle; otherwise PAD holds.
- `tlast` on the first word (`idx`==0): one-word block, `tnwords`=1.
- Reset asserted mid-message: the partial accumulator and any pending output are discarded with no flush.
- `s_axis_tvalid` low: `idx` and storage hold indefinitely. There is no timeout.

## Structure
- Shared package `sm4_pkg`:
  - `SM4_BLK_W`=128, `SM4_WORD_W`=32.
  - Pad constant `SM4_PAD_WORD`=32'h8000_0000.
  - FSM state encoding (ACC, PAD).
- No sub-module is required. The output register is written inline as a single-entry holding stage.

## Test plan
- `PAD_MODE`=0, words 01234567, 89ABCDEF, FEDCBA98, 76543210 (last) -> one block 0123456789ABCDEFFEDCBA9876543210, `tlast`=1, `tnwords`=4, valid 1 cycle after the 4th word.
- `PAD_MODE`=0, 3 words AAAAAAAA, BBBBBBBB, CCCCCCCC (last on 3rd) -> AAAAAAAABBBBBBBBCCCCCCCC00000000, `tnwords`=3.
- `PAD_MODE`=1, 1 word 11111111 (last) -> 11111111800000000000000000000000, `tnwords`=1, `tlast`=1.
- `PAD_MODE`=1, 4 words (last on 4th) -> data block with `tlast`=0, `tnwords`=4, then 8000...0 with `tlast`=1, `tnwords`=0. `s_axis_tready`=0 during PAD.
- Backpressure: stream 12 words, `m_axis_tready` toggling randomly -> 3 blocks in order with no loss or duplication, payload stable while stalled, and a no-bubble transfer at 100% `m_axis_tready`.
- Reset (`reset_n` low) after 2 words, then 4 fresh words -> only the fresh block appears, with `idx` restarted at 0.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 datapath widths, padding constant and packer FSM encoding.
package sm4_pkg;

    localparam int SM4_BLK_W  = 128;
    localparam int SM4_WORD_W = 32;

    localparam logic [SM4_WORD_W-1:0] SM4_PAD_WORD = 32'h8000_0000;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_PAD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/sm4_axis_pack32to128.sv
// Folds 32-bit AXI-Stream words into big-endian 128-bit SM4 blocks and pads the final partial block.
// Latency: a block is valid the cycle after its completing word is accepted; full rate is 1 word/cycle.
// Backpressure: input stalls while the output register is full and not draining, and during PAD.
module sm4_axis_pack32to128
    import sm4_pkg::*;
#(
    parameter int PAD_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SM4_WORD_W-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [SM4_BLK_W-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [2:0]            m_axis_tnwords,
    input  logic                  m_axis_tready
);

    localparam bit PAD_EN = (PAD_MODE != 0);

    pack_state_e                state_q, state_d;
    logic [1:0]                 idx_q, idx_d;
    logic [2:0][SM4_WORD_W-1:0] word_q, word_d;
    logic [SM4_BLK_W-1:0]       blk_q, blk_d;
    logic                       last_q, last_d;
    logic [2:0]                 nw_q, nw_d;
    logic                       vld_q;
    logic                       load;
    logic                       out_free;
    logic                       s_acc;
    logic [SM4_WORD_W-1:0]      pad_w;
    logic [SM4_WORD_W-1:0]      slot0, slot1, slot2, slot3;

    assign out_free      = !vld_q || m_axis_tready;
    assign s_axis_tready = reset_n && (state_q == ST_ACC) && out_free;
    assign s_acc         = s_axis_tvalid && s_axis_tready;

    // Slot k holds a stored word below idx, the live word at idx, the pad word just after it.
    assign pad_w = PAD_EN ? SM4_PAD_WORD : '0;
    assign slot0 = (idx_q == 2'd0) ? s_axis_tdata : word_q[0];
    assign slot1 = (idx_q >  2'd1) ? word_q[1] :
                   (idx_q == 2'd1) ? s_axis_tdata : pad_w;
    assign slot2 = (idx_q == 2'd3) ? word_q[2] :
                   (idx_q == 2'd2) ? s_axis_tdata :
                   (idx_q == 2'd1) ? pad_w : '0;
    assign slot3 = (idx_q == 2'd3) ? s_axis_tdata :
                   (idx_q == 2'd2) ? pad_w : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        load    = 1'b0;
        blk_d   = blk_q;
        last_d  = last_q;
        nw_d    = nw_q;
        case (state_q)
            ST_ACC: begin
                if (s_acc) begin
                    if (s_axis_tlast || idx_q == 2'd3) begin
                        load   = 1'b1;
                        idx_d  = 2'd0;
                        blk_d  = {slot0, slot1, slot2, slot3};
                        nw_d   = {1'b0, idx_q} + 3'd1;
                        // A full final block leaves no room for the pad word, so it travels alone.
                        last_d = s_axis_tlast && !(PAD_EN && idx_q == 2'd3);
                        if (PAD_EN && idx_q == 2'd3 && s_axis_tlast) begin
                            state_d = ST_PAD;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                        case (idx_q)
                            2'd0:    word_d[0] = s_axis_tdata;
                            2'd1:    word_d[1] = s_axis_tdata;
                            2'd2:    word_d[2] = s_axis_tdata;
                            default: word_d    = word_q;
                        endcase
                    end
                end
            end
            ST_PAD: begin
                if (out_free) begin
                    load    = 1'b1;
                    blk_d   = {SM4_PAD_WORD, {(SM4_BLK_W-SM4_WORD_W){1'b0}}};
                    nw_d    = 3'd0;
                    last_d  = 1'b1;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ACC;
            idx_q   <= '0;
            word_q  <= '0;
            blk_q   <= '0;
            last_q  <= 1'b0;
            nw_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            if (load) begin
                vld_q  <= 1'b1;
                blk_q  <= blk_d;
                last_q <= last_d;
                nw_q   <= nw_d;
            end else if (m_axis_tready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata   = blk_q;
    assign m_axis_tvalid  = vld_q;
    assign m_axis_tlast   = last_q;
    assign m_axis_tnwords = nw_q;

endmodule

// File: tb/tb_sm4_axis_pack32to128.sv
// Bench for the 32->128 SM4 packer: one instance per padding mode, message-level reference model.
module tb_sm4_axis_pack32to128;

    typedef struct packed {
        logic [127:0] d;
        logic         last;
        logic [2:0]   nw;
    } blk_t;

    logic         clk;
    logic         reset_n;
    logic [31:0]  s_dat  [2];
    logic         s_vld  [2];
    logic         s_last [2];
    logic         s_rdy  [2];
    logic [127:0] m_dat  [2];
    logic         m_vld  [2];
    logic         m_last [2];
    logic [2:0]   m_nw   [2];
    logic         m_rdy  [2];
    int           rdy_mode [2];   // 0 always ready, 1 random, 2 stalled

    int   vecs = 0;
    int   errs = 0;
    int   cyc  = 0;
    blk_t expq0[$];
    blk_t expq1[$];

    localparam logic [127:0] PAD_BLK = {32'h8000_0000, 96'h0};

    sm4_axis_pack32to128 #(.PAD_MODE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tdata(s_dat[0]), .s_axis_tvalid(s_vld[0]), .s_axis_tlast(s_last[0]),
        .s_axis_tready(s_rdy[0]),
        .m_axis_tdata(m_dat[0]), .m_axis_tvalid(m_vld[0]), .m_axis_tlast(m_last[0]),
        .m_axis_tnwords(m_nw[0]), .m_axis_tready(m_rdy[0])
    );

    sm4_axis_pack32to128 #(.PAD_MODE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tdata(s_dat[1]), .s_axis_tvalid(s_vld[1]), .s_axis_tlast(s_last[1]),
        .s_axis_tready(s_rdy[1]),
        .m_axis_tdata(m_dat[1]), .m_axis_tvalid(m_vld[1]), .m_axis_tlast(m_last[1]),
        .m_axis_tnwords(m_nw[1]), .m_axis_tready(m_rdy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int m);
        return (m == 0) ? expq0.size() : expq1.size();
    endfunction

    task automatic qpush(input int m, input blk_t b);
        if (m == 0) expq0.push_back(b);
        else        expq1.push_back(b);
    endtask

    // Message-level model: chop into 4-word blocks, first word in the top slot, pad the tail.
    task automatic model_msg(input int m, input logic [31:0] w[$]);
        int n;
        n = w.size();
        for (int b = 0; b * 4 < n; b++) begin
            int   cnt;
            bit   fin;
            blk_t e;
            cnt = (n - b * 4 > 4) ? 4 : n - b * 4;
            fin = (b * 4 + cnt == n);
            e.d = '0;
            for (int k = 0; k < 4; k++) begin
                logic [31:0] v;
                v = '0;
                if (k < cnt)                  v = w[b * 4 + k];
                else if (m == 1 && k == cnt)  v = 32'h8000_0000;
                e.d[127 - 32 * k -: 32] = v;
            end
            e.nw   = cnt[2:0];
            e.last = fin && (m == 0 || cnt < 4);
            qpush(m, e);
            if (m == 1 && fin && cnt == 4) qpush(m, '{d: PAD_BLK, last: 1'b1, nw: 3'd0});
        end
    endtask

    // Ready driver runs at posedge+2 so the main sequence can retarget it at posedge+1.
    initial begin
        m_rdy[0] = 1'b1;
        m_rdy[1] = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            for (int m = 0; m < 2; m++) begin
                case (rdy_mode[m])
                    0:       m_rdy[m] = 1'b1;
                    1:       m_rdy[m] = 1'($urandom_range(0, 1));
                    default: m_rdy[m] = 1'b0;
                endcase
            end
        end
    end

    // Every valid cycle must show the head of the expected queue; a handshake retires it.
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            for (int m = 0; m < 2; m++) begin
                if (m_vld[m]) begin
                    if (qsize(m) == 0) begin
                        vecs++;
                        assert (qsize(m) != 0) else begin
                            errs++;
                            $error("FAIL spurious_blk mode%0d observed=%h expected=none", m, m_dat[m]);
                        end
                    end else begin
                        chk($sformatf("blk_mode%0d", m), {m_dat[m], m_last[m], m_nw[m]},
                            (m == 0) ? expq0[0] : expq1[0]);
                        if (m_rdy[m]) begin
                            if (m == 0) void'(expq0.pop_front());
                            else        void'(expq1.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic put_word(input int m, input logic [31:0] w, input bit l);
        int t;
        t = 0;
        s_dat[m]  = w;
        s_vld[m]  = 1'b1;
        s_last[m] = l;
        @(negedge clk);
        while (!s_rdy[m] && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("in_accept_mode%0d", m), 132'(t < 200), 132'(1));
        @(posedge clk);
        #1;
        s_vld[m]  = 1'b0;
        s_last[m] = 1'b0;
    endtask

    task automatic send_msg(input int m, input logic [31:0] w[$], input bit gaps);
        model_msg(m, w);
        for (int i = 0; i < w.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            put_word(m, w[i], i == w.size() - 1);
        end
    endtask

    task automatic wait_drain(input int m);
        int t;
        t = 0;
        while (qsize(m) != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("drain_mode%0d", m), 132'(t < 1000), 132'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk({tag, "_s_rdy"}, 132'(s_rdy[m]), 132'(0));
            chk({tag, "_m_vld"}, 132'(m_vld[m]), 132'(0));
            chk({tag, "_m_out"}, {m_dat[m], m_last[m], m_nw[m]}, 132'(0));
        end
    endtask

    initial begin
        logic [31:0] q[$];
        int          c0;
        reset_n     = 1'b0;
        rdy_mode[0] = 0;
        rdy_mode[1] = 0;
        for (int m = 0; m < 2; m++) begin
            s_dat[m]  = '0;
            s_vld[m]  = 1'b0;
            s_last[m] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Full message, zero-fill mode: block valid one cycle after the 4th word.
        q = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
        send_msg(0, q, 1'b0);
        chk("t1_vld", 132'(m_vld[0]), 132'(1));
        chk("t1_blk", {m_dat[0], m_last[0], m_nw[0]},
            {128'h0123456789ABCDEFFEDCBA9876543210, 1'b1, 3'd4});
        wait_drain(0);

        q = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC};
        send_msg(0, q, 1'b0);
        chk("t2_blk", {m_dat[0], m_last[0], m_nw[0]},
            {128'hAAAAAAAABBBBBBBBCCCCCCCC00000000, 1'b1, 3'd3});
        wait_drain(0);

        q = '{32'h11111111};
        send_msg(1, q, 1'b0);
        chk("t3_blk", {m_dat[1], m_last[1], m_nw[1]},
            {128'h11111111800000000000000000000000, 1'b1, 3'd1});
        wait_drain(1);

        // Full final block with pad: hold the output stalled so PAD must wait.
        rdy_mode[1] = 2;
        q = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
        send_msg(1, q, 1'b0);
        chk("t4_data_blk", {m_dat[1], m_last[1], m_nw[1]},
            {128'h00000001000000020000000300000004, 1'b0, 3'd4});
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t4_hold_vld", 132'(m_vld[1]), 132'(1));
            chk("t4_hold_rdy", 132'(s_rdy[1]), 132'(0));
        end
        rdy_mode[1] = 0;
        @(negedge clk);
        chk("t4_pad_s_rdy", 132'(s_rdy[1]), 132'(0));
        @(posedge clk);
        #1;
        chk("t4_pad_vld", 132'(m_vld[1]), 132'(1));
        chk("t4_pad_blk", {m_dat[1], m_last[1], m_nw[1]}, {PAD_BLK, 1'b1, 3'd0});
        chk("t4_acc_s_rdy", 132'(s_rdy[1]), 132'(1));
        wait_drain(1);

        // Random data, random downstream stalls, random input gaps.
        rdy_mode[0] = 1;
        rdy_mode[1] = 1;
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 4; r++) begin
                int len;
                len = (r == 0) ? 12 : int'($urandom_range(1, 9));
                q.delete();
                for (int i = 0; i < len; i++) q.push_back($urandom);
                send_msg(m, q, 1'b1);
            end
            wait_drain(m);
        end
        rdy_mode[0] = 0;
        rdy_mode[1] = 0;
        @(posedge clk);
        #1;

        // Full rate: 12 words in 12 cycles, then one-word messages back to back with no bubble.
        q.delete();
        for (int i = 0; i < 12; i++) q.push_back($urandom);
        c0 = cyc;
        send_msg(0, q, 1'b0);
        chk("rate_12w", 132'(cyc - c0), 132'(12));
        wait_drain(0);
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            q = '{32'(32'hC0DE0000 + i)};
            send_msg(0, q, 1'b0);
            chk("nobubble_vld", 132'(m_vld[0]), 132'(1));
            chk("nobubble_blk", {m_dat[0], m_last[0], m_nw[0]},
                {32'(32'hC0DE0000 + i), 96'h0, 1'b1, 3'd1});
        end
        chk("nobubble_cycles", 132'(cyc - c0), 132'(4));
        wait_drain(0);

        // Reset mid-message discards the partial words in both instances.
        for (int m = 0; m < 2; m++) begin
            put_word(m, 32'hDEAD0000, 1'b0);
            put_word(m, 32'hDEAD0001, 1'b0);
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_state("midrst");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        q = '{32'h10101010, 32'h20202020, 32'h30303030, 32'h40404040};
        send_msg(0, q, 1'b0);
        chk("rst_fresh_blk", {m_dat[0], m_last[0], m_nw[0]},
            {128'h10101010202020203030303040404040, 1'b1, 3'd4});
        send_msg(1, q, 1'b0);
        wait_drain(0);
        wait_drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
